rx_fsrc_capture_gate: RTL and testbench
=======================================

RX_FSRC_CAPTURE_GATE -- requirements
Module: rx_fsrc_capture_gate

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: rx_glblclk is the only clock and rx_transport_reset_gc is the reset.
REQ-002 Parameter DATA_WIDTH, default 1024: width of the sample data word.
REQ-003 Parameter CNT_WIDTH, default 32: width of the length, timestamp and drop counters.
REQ-004 rx_glblclk  input  1  clock.
REQ-005 rx_transport_reset_gc  input  1  synchronous active-high reset.
REQ-006 rx_sample_data_fsrc  input  DATA_WIDTH  gated sample word from the FSRC wait-valid stage.
REQ-007 rx_sample_valid_fsrc  input  1  word qualifier; has no backpressure.
REQ-008 arm  input  1  single-cycle request to start a capture.
REQ-009 abort  input  1  single-cycle request to cancel the current capture.
REQ-010 capture_len  input  CNT_WIDTH  number of beats to capture; sampled on arm.
REQ-011 m_axis_tdata  output  DATA_WIDTH  captured word.
REQ-012 m_axis_tvalid  output  1  captured word is valid.
REQ-013 m_axis_tlast  output  1  marks the final beat of the capture.
REQ-014 m_axis_tready  input  1  downstream accept.
REQ-015 busy  output  1  high in ARMED, CAPTURE or DRAIN.
REQ-016 done  output  1  high in DONE.
REQ-017 overflow  output  1  sticky flag: at least one beat was dropped.
REQ-018 drop_cnt  output  CNT_WIDTH  number of dropped beats; saturates at all-ones.
REQ-019 first_valid_ts  output  CNT_WIDTH  timestamp of the first captured beat.

Function
REQ-020 A free-running counter ts SHALL clear to 0 on reset, increment by 1 every cycle, and wrap modulo 2^CNT_WIDTH.
REQ-021 Output buffering SHALL be a 2-entry FIFO; m_axis_tdata/tlast SHALL be taken from the FIFO head and m_axis_tvalid SHALL equal FIFO not-empty.
REQ-022 A beat is transferred when m_axis_tvalid and m_axis_tready are both high; the FIFO head and m_axis_tlast SHALL hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 Latency: an accepted input beat at cycle N SHALL appear on m_axis_tvalid at cycle N+1 when the FIFO is empty at N.
REQ-024 The state machine SHALL have the states IDLE, ARMED, CAPTURE, DRAIN and DONE.
REQ-025 IDLE, or DONE, with arm=1 and capture_len!=0: latch capture_len into a remaining counter, clear overflow and drop_cnt, clear done, and go to ARMED.
REQ-026 IDLE, or DONE, with arm=1 and capture_len==0: go to DONE with no beats emitted; overflow and drop_cnt SHALL be cleared.
REQ-027 ARMED: on the first rx_sample_valid_fsrc=1, latch ts into first_valid_ts and accept the beat; go to CAPTURE, or to DRAIN if remaining==1.
REQ-028 CAPTURE: each rx_sample_valid_fsrc=1 beat SHALL be accepted and SHALL decrement remaining; the beat that takes remaining from 1 to 0 SHALL carry tlast=1, and the state SHALL then go to DRAIN.
REQ-029 Acceptance: a beat is written only if the FIFO has room in that cycle, counting a simultaneous pop as freeing an entry.
REQ-030 Drop: a valid beat in ARMED or CAPTURE that finds the FIFO full SHALL be dropped.
  - overflow SHALL be set and drop_cnt SHALL increment.
  - remaining SHALL NOT decrement.
  - In ARMED, first_valid_ts SHALL NOT latch and the state SHALL remain ARMED.
REQ-031 Input beats in IDLE, DRAIN or DONE SHALL be ignored and SHALL NOT count as drops.
REQ-032 DRAIN: when the FIFO becomes empty (the last beat with tlast is transferred), go to DONE; done SHALL assert in the cycle after that transfer.
REQ-033 arm in ARMED, CAPTURE or DRAIN SHALL be ignored.
REQ-034 abort in ARMED, CAPTURE, DRAIN or DONE SHALL:
  - flush the FIFO;
  - go to IDLE, with m_axis_tvalid=0 on the next cycle;
  - retain overflow, drop_cnt and first_valid_ts.
REQ-035 abort and arm asserted in the same cycle: abort SHALL win and arm SHALL be ignored.
REQ-036 tlast SHALL be 0 on every beat other than the final one.
REQ-037 drop_cnt SHALL saturate at all-ones and SHALL NOT wrap.

Reset
REQ-038 Reset SHALL force, in the cycle after it is sampled high, and regardless of the current state or an in-flight capture:
  - state to IDLE, with the FIFO emptied;
  - m_axis_tvalid=0, m_axis_tlast=0, busy=0, done=0, overflow=0;
  - drop_cnt=0, first_valid_ts=0, ts=0.
REQ-039 m_axis_tdata SHALL NOT require a reset value.

Verification
REQ-040 Basic capture: capture_len=4, tready=1, valid on 6 consecutive cycles starting 3 cycles after arm -> exactly 4 beats out, the 4th with tlast=1, first_valid_ts = ts of the first valid cycle, done=1, drop_cnt=0.
REQ-041 Backpressure: capture_len=8, valid every cycle, tready=0 for 5 cycles -> 2 beats buffered, overflow=1, drop_cnt=3; all 8 beats delivered in order and data unchanged while stalled.
REQ-042 Length one, then zero: capture_len=1 -> a single beat with tlast=1, then DONE; re-arm with capture_len=0 -> DONE with no output and overflow cleared.
REQ-043 Abort mid-capture: abort after 2 of 10 beats with 2 beats pending in the FIFO -> m_axis_tvalid=0 on the next cycle, busy=0, done=0; a later arm with capture_len=3 yields 3 fresh beats.
REQ-044 Reset mid-capture: rx_transport_reset_gc pulsed during CAPTURE -> all outputs equal their REQ-038 values on the next cycle; a following arm captures normally.
REQ-045 Simultaneous abort and arm in DONE -> IDLE, not ARMED; no beats are emitted for subsequent valid input.

Source files
------------

// File: rtl/rx_fsrc_capture_gate.sv
// Gated capture of FSRC sample words into a 2-deep AXI-Stream output buffer.
// Arm/abort control, drop accounting and first-beat timestamping.
module rx_fsrc_capture_gate #(
  parameter int DATA_WIDTH = 1024,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  rx_glblclk,
  input  logic                  rx_transport_reset_gc,
  input  logic [DATA_WIDTH-1:0] rx_sample_data_fsrc,
  input  logic                  rx_sample_valid_fsrc,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [CNT_WIDTH-1:0]  capture_len,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic [CNT_WIDTH-1:0]  first_valid_ts
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_WIDTH-1:0]  r_ts;
  logic [CNT_WIDTH-1:0]  r_remaining;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;
  logic [CNT_WIDTH-1:0]  r_first_valid_ts;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic [1:0]            r_fifo_last;
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_fifo_cnt;

  logic w_fifo_nonempty;
  logic w_pop;
  logic w_room;
  logic w_push;
  logic w_push_last;
  logic w_drop;
  logic w_flush;
  logic w_clear_stats;
  logic w_load_len;
  logic w_latch_ts;

  assign w_fifo_nonempty = (r_fifo_cnt != 2'd0);
  assign w_pop           = w_fifo_nonempty && m_axis_tready;
  // A pop in the same cycle frees the slot the incoming beat needs.
  assign w_room          = (r_fifo_cnt != 2'd2) || w_pop;
  assign w_push_last     = (r_remaining == CNT_WIDTH'(1));

  // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_push        = 1'b0;
    w_drop        = 1'b0;
    w_flush       = 1'b0;
    w_clear_stats = 1'b0;
    w_load_len    = 1'b0;
    w_latch_ts    = 1'b0;

    if (abort) begin
      w_flush     = 1'b1;
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            w_clear_stats = 1'b1;
            if (capture_len != '0) begin
              w_load_len  = 1'b1;
              w_state_nxt = S_ARMED;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_ARMED, S_CAPTURE: begin
          if (rx_sample_valid_fsrc) begin
            if (w_room) begin
              w_push      = 1'b1;
              w_latch_ts  = (r_state == S_ARMED);
              w_state_nxt = w_push_last ? S_DRAIN : S_CAPTURE;
            end else begin
              w_drop = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!w_fifo_nonempty || (r_fifo_cnt == 2'd1 && w_pop)) begin
            w_state_nxt = S_DONE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge rx_glblclk) begin
    if (rx_transport_reset_gc) begin
      r_state          <= S_IDLE;
      r_ts             <= '0;
      r_remaining      <= '0;
      r_drop_cnt       <= '0;
      r_first_valid_ts <= '0;
      r_overflow       <= 1'b0;
      r_fifo_last      <= '0;
      r_rd_ptr         <= 1'b0;
      r_wr_ptr         <= 1'b0;
      r_fifo_cnt       <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ts    <= r_ts + CNT_WIDTH'(1);

      if (w_load_len) begin
        r_remaining <= capture_len;
      end else if (w_push) begin
        r_remaining <= r_remaining - CNT_WIDTH'(1);
      end

      if (w_clear_stats) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
        end
      end

      if (w_latch_ts) begin
        r_first_valid_ts <= r_ts;
      end

      if (w_flush) begin
        r_rd_ptr   <= 1'b0;
        r_wr_ptr   <= 1'b0;
        r_fifo_cnt <= 2'd0;
      end else begin
        if (w_push) begin
          r_fifo_last[r_wr_ptr] <= w_push_last;
          r_wr_ptr              <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        case ({w_push, w_pop})
          2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
          2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
          default: r_fifo_cnt <= r_fifo_cnt;
        endcase
      end
    end
  end

  // NOTE: the data storage has no reset; valid/last are gated by the reset occupancy count instead.
  always_ff @(posedge rx_glblclk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= rx_sample_data_fsrc;
    end
  end

  assign m_axis_tdata   = r_fifo_data[r_rd_ptr];
  assign m_axis_tvalid  = w_fifo_nonempty;
  assign m_axis_tlast   = w_fifo_nonempty && r_fifo_last[r_rd_ptr];
  assign busy           = (r_state == S_ARMED) || (r_state == S_CAPTURE) || (r_state == S_DRAIN);
  assign done           = (r_state == S_DONE);
  assign overflow       = r_overflow;
  assign drop_cnt       = r_drop_cnt;
  assign first_valid_ts = r_first_valid_ts;

endmodule

// File: tb/tb_rx_fsrc_capture_gate.sv
// Bench for rx_fsrc_capture_gate: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_rx_fsrc_capture_gate;

  localparam int DW = 32;
  localparam int CW = 8;
  localparam int MAX_DROPS = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic          valid = 1'b0;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] len = '0;
  logic          tready = 1'b0;

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] first_valid_ts;

  always #5 clk = ~clk;

  rx_fsrc_capture_gate #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) u_dut (
    .rx_glblclk           (clk),
    .rx_transport_reset_gc(rst),
    .rx_sample_data_fsrc  (din),
    .rx_sample_valid_fsrc (valid),
    .arm                  (arm),
    .abort                (abort),
    .capture_len          (len),
    .m_axis_tdata         (tdata),
    .m_axis_tvalid        (tvalid),
    .m_axis_tlast         (tlast),
    .m_axis_tready        (tready),
    .busy                 (busy),
    .done                 (done),
    .overflow             (overflow),
    .drop_cnt             (drop_cnt),
    .first_valid_ts       (first_valid_ts)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  typedef enum {M_IDLE, M_ARMED, M_CAPTURE, M_DRAIN, M_DONE} mode_t;

  beat_t         q[$];
  mode_t         m_mode = M_IDLE;
  int            m_left = 0;
  bit            m_ovf = 0;
  int            m_drops = 0;
  logic [CW-1:0] m_ts = '0;
  logic [CW-1:0] m_fts = '0;
  bit            model_live = 0;

  task automatic model_step();
    bit pop;
    bit room;
    if (rst) begin
      q.delete();
      m_mode = M_IDLE; m_left = 0; m_ovf = 0; m_drops = 0; m_ts = '0; m_fts = '0;
      model_live = 1;
      return;
    end
    if (!model_live) return;
    pop  = (q.size() != 0) && tready;
    room = (q.size() < 2) || pop;
    if (pop) void'(q.pop_front());
    if (abort) begin
      q.delete();
      m_mode = M_IDLE;
    end else begin
      case (m_mode)
        M_IDLE, M_DONE: if (arm) begin
          m_ovf = 0; m_drops = 0;
          if (len != 0) begin m_left = int'(len); m_mode = M_ARMED; end
          else m_mode = M_DONE;
        end
        M_ARMED, M_CAPTURE: if (valid) begin
          if (room) begin
            if (m_mode == M_ARMED) m_fts = m_ts;
            q.push_back('{last: (m_left == 1), data: din});
            m_left--;
            m_mode = (m_left == 0) ? M_DRAIN : M_CAPTURE;
          end else begin
            m_ovf = 1;
            if (m_drops < MAX_DROPS) m_drops++;
          end
        end
        M_DRAIN: if (q.size() == 0) m_mode = M_DONE;
        default: ;
      endcase
    end
    m_ts = m_ts + 1'b1;
  endtask

  always @(posedge clk) model_step();

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("tvalid", tvalid, q.size() != 0);
      if (q.size() != 0) begin
        check("tdata", tdata, q[0].data);
        check("tlast", tlast, q[0].last);
      end
      check("busy", busy, m_mode inside {M_ARMED, M_CAPTURE, M_DRAIN});
      check("done", done, m_mode == M_DONE);
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drops);
      check("first_valid_ts", first_valid_ts, m_fts);
    end
  end

  // Log of delivered beats, used by the literal expectations.
  logic [DW-1:0] got[$];
  bit            got_last[$];

  always @(negedge clk) begin
    if (!rst && tvalid === 1'b1 && tready) begin
      got.push_back(tdata);
      got_last.push_back(tlast);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    got.delete();
    got_last.delete();
  endtask

  task automatic do_reset();
    arm = 0; abort = 0; valid = 0;
    rst = 1;
    cyc(1);
    rst = 0;
  endtask

  function automatic int count_lasts();
    int n = 0;
    foreach (got_last[i]) n += got_last[i];
    return n;
  endfunction

  initial begin
    cyc(2);

    // Reset values, then basic capture: arm at C0, valid C3..C8 -> ts of first beat is 3.
    do_reset();
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_first_ts", first_valid_ts, 0);
    clear_log();
    tready = 1; len = 4; arm = 1;
    cyc(1);
    arm = 0;
    cyc(2);
    for (int i = 0; i < 6; i++) begin
      valid = 1; din = 32'hA000 + i;
      cyc(1);
    end
    valid = 0;
    cyc(3);
    check("basic_beats", got.size(), 4);
    if (got.size() == 4) begin
      check("basic_first_data", got[0], 32'hA000);
      check("basic_last_data", got[3], 32'hA003);
      check("basic_4th_tlast", got_last[3], 1);
    end
    check("basic_tlast_count", count_lasts(), 1);
    check("basic_first_ts", first_valid_ts, 3);
    check("basic_done", done, 1);
    check("basic_drop_cnt", drop_cnt, 0);

    // Backpressure: tready low for 5 cycles, 3 drops, 8 beats in order.
    do_reset();
    clear_log();
    tready = 0; len = 8; arm = 1;
    cyc(1);
    arm = 0;
    for (int c = 1; c <= 13; c++) begin
      valid = 1; din = 32'h100 + c; tready = (c >= 6);
      if (c == 4 || c == 6) begin
        check("bp_stall_tvalid", tvalid, 1);
        check("bp_stall_tdata", tdata, 32'h101);
      end
      cyc(1);
    end
    valid = 0;
    cyc(4);
    check("bp_overflow", overflow, 1);
    check("bp_drop_cnt", drop_cnt, 3);
    check("bp_beats", got.size(), 8);
    if (got.size() == 8) begin
      check("bp_data2", got[1], 32'h102);
      check("bp_data3", got[2], 32'h106);
      check("bp_data8", got[7], 32'h10B);
      check("bp_tlast8", got_last[7], 1);
    end
    check("bp_tlast_count", count_lasts(), 1);
    check("bp_done", done, 1);

    // Zero length from DONE clears the sticky flag and emits nothing.
    clear_log();
    len = 0; arm = 1;
    cyc(1);
    arm = 0;
    check("zero_done", done, 1);
    check("zero_overflow", overflow, 0);
    check("zero_drop_cnt", drop_cnt, 0);
    valid = 1; din = 32'hDEAD;
    cyc(3);
    valid = 0;
    check("zero_no_beats", got.size(), 0);

    // Length one: a single beat carrying tlast.
    len = 1; arm = 1;
    cyc(1);
    arm = 0;
    for (int i = 0; i < 3; i++) begin
      valid = 1; din = 32'h200 + i;
      cyc(1);
    end
    valid = 0;
    cyc(3);
    check("len1_beats", got.size(), 1);
    if (got.size() == 1) begin
      check("len1_data", got[0], 32'h200);
      check("len1_tlast", got_last[0], 1);
    end
    check("len1_done", done, 1);

    // Abort with two beats pending, then a fresh 3-beat capture.
    do_reset();
    clear_log();
    tready = 0; len = 10; arm = 1;
    cyc(1);
    arm = 0;
    for (int i = 0; i < 2; i++) begin
      valid = 1; din = 32'h300 + i;
      cyc(1);
    end
    valid = 0;
    check("abort_pending", tvalid, 1);
    abort = 1;
    cyc(1);
    abort = 0;
    check("abort_tvalid", tvalid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    tready = 1; len = 3; arm = 1;
    cyc(1);
    arm = 0;
    for (int i = 0; i < 3; i++) begin
      valid = 1; din = 32'h310 + i;
      cyc(1);
    end
    valid = 0;
    cyc(4);
    check("rearm_beats", got.size(), 3);
    if (got.size() == 3) begin
      check("rearm_first", got[0], 32'h310);
      check("rearm_third", got[2], 32'h312);
      check("rearm_tlast", got_last[2], 1);
    end
    check("rearm_done", done, 1);

    // Reset during CAPTURE with pending beats and drops.
    do_reset();
    clear_log();
    tready = 0; len = 10; arm = 1;
    cyc(1);
    arm = 0;
    for (int i = 0; i < 4; i++) begin
      valid = 1; din = 32'h400 + i;
      cyc(1);
    end
    check("midrst_pre_ovf", overflow, 1);
    rst = 1;
    cyc(1);
    rst = 0; valid = 0;
    check("midrst_tvalid", tvalid, 0);
    check("midrst_tlast", tlast, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_drop_cnt", drop_cnt, 0);
    check("midrst_first_ts", first_valid_ts, 0);
    clear_log();
    tready = 1; len = 2; arm = 1;
    cyc(1);
    arm = 0;
    for (int i = 0; i < 2; i++) begin
      valid = 1; din = 32'h410 + i;
      cyc(1);
    end
    valid = 0;
    cyc(4);
    check("postrst_beats", got.size(), 2);
    check("postrst_done", done, 1);

    // Abort and arm together in DONE: back to IDLE, later input ignored.
    clear_log();
    len = 5; arm = 1; abort = 1;
    cyc(1);
    arm = 0; abort = 0;
    check("armabort_busy", busy, 0);
    check("armabort_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      valid = 1; din = 32'h500 + i;
      cyc(1);
    end
    valid = 0;
    cyc(2);
    check("armabort_no_beats", got.size(), 0);

    // drop_cnt saturation with a narrow counter.
    do_reset();
    tready = 0; len = 3; arm = 1;
    cyc(1);
    arm = 0;
    valid = 1;
    cyc(270);
    valid = 0;
    check("sat_drop_cnt", drop_cnt, MAX_DROPS);
    check("sat_overflow", overflow, 1);
    abort = 1;
    cyc(1);
    abort = 0;

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      valid  = ($urandom_range(0, 99) < 60);
      din    = $urandom;
      tready = ($urandom_range(0, 99) < 70);
      arm    = ($urandom_range(0, 99) < 6);
      abort  = ($urandom_range(0, 199) < 2);
      len    = CW'($urandom_range(0, 7));
      rst    = ($urandom_range(0, 999) < 3);
      cyc(1);
    end
    arm = 0; abort = 0; valid = 0; rst = 0;
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
